// File: rtl/drum_grid_tdm_solver.sv
// Time-multiplexed 2-D finite-difference membrane solver: one node per cycle through a
// 2-stage datapath, three rotating displacement banks (prev/cur/next), tap sample per step.
`timescale 1ns/1ps
module drum_grid_tdm_solver #(
  parameter int SIZE      = 10,
  parameter int WIDTH     = 18,
  parameter int RHO_SHIFT = 2,
  parameter int ETA_SHIFT = 10,
  parameter int AW        = $clog2(SIZE*SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [AW-1:0]           load_addr,
  input  logic signed [WIDTH-1:0] load_data,
  input  logic                    step_start,
  input  logic [AW-1:0]           tap_addr,
  output logic                    busy,
  output logic                    step_done,
  output logic signed [WIDTH-1:0] sample,
  output logic                    sample_valid,
  output logic                    sat_flag
);
  localparam int N  = SIZE * SIZE;
  localparam int IW = WIDTH + 4;
  localparam logic [AW:0] N_W = (AW+1)'(N);
  localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [IW-1:0]    MAX_V = IW'(MAX_W);
  localparam logic signed [IW-1:0]    MIN_V = IW'(MIN_W);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_ROTATE = 2'd3;

  logic [1:0]    state;
  logic          drain_cnt;
  logic [AW-1:0] idx, row_q, col_q, tap_q;
  logic [1:0]    ptr_prev, ptr_cur, ptr_next;

  logic signed [WIDTH-1:0] bank [3][N];

  logic                    s1_valid;
  logic [AW-1:0]           s1_addr;
  logic signed [WIDTH-1:0] s1_u, s1_up, s1_dn, s1_lf, s1_rt, s1_prev;

  logic signed [IW-1:0]    u, up, dn, lf, rt, u_prev, lap, acc, res;
  logic signed [WIDTH-1:0] res_sat;
  logic                    res_clip;
  logic                    load_we, scan_we;
  logic [AW-1:0]           a_up, a_dn, a_lf, a_rt;

  assign busy    = (state != S_IDLE);
  assign load_we = (state == S_IDLE) && load_en && ({1'b0, load_addr} < N_W);
  assign scan_we = s1_valid;
  assign a_up    = idx - AW'(SIZE);
  assign a_dn    = idx + AW'(SIZE);
  assign a_lf    = idx - 1'b1;
  assign a_rt    = idx + 1'b1;

  // Each node owns its storage so the bank array has exactly one driver per element.
  for (genvar b = 0; b < 3; b++) begin : g_bank
    for (genvar a = 0; a < N; a++) begin : g_node
      logic signed [WIDTH-1:0] q;
      // NOTE: the node storage takes the synchronous reset because an aborted or fresh
      // run must see an all-zero grid; a RAM macro could not be cleared this way.
      always_ff @(posedge clk) begin
        if (reset) begin
          q <= '0;
        end else if (scan_we && s1_addr == AW'(a) && ptr_next == 2'(b)) begin
          q <= res_sat;
        end else if (load_we && load_addr == AW'(a) &&
                     (ptr_cur == 2'(b) || ptr_prev == 2'(b))) begin
          q <= load_data;
        end
      end
      assign bank[b][a] = q;
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    u        = IW'(s1_u);
    up       = IW'(s1_up);
    dn       = IW'(s1_dn);
    lf       = IW'(s1_lf);
    rt       = IW'(s1_rt);
    u_prev   = IW'(s1_prev);
    lap      = up + dn + lf + rt - (u <<< 2);
    acc      = (u <<< 1) + (lap >>> RHO_SHIFT) - u_prev + (u_prev >>> ETA_SHIFT);
    res      = acc - (acc >>> ETA_SHIFT);
    res_sat  = res[WIDTH-1:0];
    res_clip = 1'b0;
    if (res > MAX_V) begin
      res_sat  = MAX_W;
      res_clip = 1'b1;
    end else if (res < MIN_V) begin
      res_sat  = MIN_W;
      res_clip = 1'b1;
    end
  end

  // Stage 1: fetch the stencil from the cur/prev banks; off-grid neighbours read as zero.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_u     <= '0;
      s1_up    <= '0;
      s1_dn    <= '0;
      s1_lf    <= '0;
      s1_rt    <= '0;
      s1_prev  <= '0;
    end else begin
      s1_valid <= (state == S_SCAN);
      s1_addr  <= idx;
      s1_u     <= bank[ptr_cur][idx];
      s1_prev  <= bank[ptr_prev][idx];
      s1_up    <= (row_q != '0)              ? bank[ptr_cur][a_up] : '0;
      s1_dn    <= (row_q != AW'(SIZE - 1))   ? bank[ptr_cur][a_dn] : '0;
      s1_lf    <= (col_q != '0)              ? bank[ptr_cur][a_lf] : '0;
      s1_rt    <= (col_q != AW'(SIZE - 1))   ? bank[ptr_cur][a_rt] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      drain_cnt    <= 1'b0;
      idx          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      tap_q        <= '0;
      ptr_prev     <= 2'd0;
      ptr_cur      <= 2'd1;
      ptr_next     <= 2'd2;
      step_done    <= 1'b0;
      sample_valid <= 1'b0;
      sample       <= '0;
      sat_flag     <= 1'b0;
    end else begin
      step_done    <= 1'b0;
      sample_valid <= 1'b0;
      if (scan_we && res_clip) sat_flag <= 1'b1;
      case (state)
        S_IDLE: begin
          if (step_start && !load_en) begin
            tap_q <= tap_addr;
            idx   <= '0;
            row_q <= '0;
            col_q <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          idx <= idx + 1'b1;
          if (col_q == AW'(SIZE - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
          if (idx == AW'(N - 1)) begin
            drain_cnt <= 1'b0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= S_ROTATE;
        end
        default: begin
          // The bank about to become cur is read here, so the sample is the new displacement.
          ptr_prev     <= ptr_cur;
          ptr_cur      <= ptr_next;
          ptr_next     <= ptr_prev;
          sample       <= ({1'b0, tap_q} < N_W) ? bank[ptr_next][tap_q] : '0;
          step_done    <= 1'b1;
          sample_valid <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_drum_grid_tdm_solver.sv
// Scoreboard bench for drum_grid_tdm_solver: a SIZE=5 instance for arithmetic and control,
// a default SIZE=10 instance for the full-grid step latency.
`timescale 1ns/1ps
module tb_drum_grid_tdm_solver;
  localparam int W   = 18;
  localparam int N5  = 25;
  localparam int N10 = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic          load_en = 1'b0, step_start = 1'b0;
  logic [4:0]    load_addr = '0, tap_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic          busy, step_done, sample_valid, sat_flag;
  logic [W-1:0]  sample;

  logic          load_en_b = 1'b0, step_start_b = 1'b0;
  logic [6:0]    load_addr_b = '0, tap_addr_b = '0;
  logic [W-1:0]  load_data_b = '0;
  logic          busy_b, step_done_b, sample_valid_b, sat_flag_b;
  logic [W-1:0]  sample_b;

  drum_grid_tdm_solver #(.SIZE(5)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .step_start(step_start), .tap_addr(tap_addr),
    .busy(busy), .step_done(step_done), .sample(sample),
    .sample_valid(sample_valid), .sat_flag(sat_flag));

  drum_grid_tdm_solver #(.SIZE(10)) dut_b (
    .clk(clk), .reset(reset), .load_en(load_en_b), .load_addr(load_addr_b),
    .load_data(load_data_b), .step_start(step_start_b), .tap_addr(tap_addr_b),
    .busy(busy_b), .step_done(step_done_b), .sample(sample_b),
    .sample_valid(sample_valid_b), .sat_flag(sat_flag_b));

  typedef struct packed {
    logic [W-1:0] smp;
    logic         sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed step must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (step_done || sample_valid) begin
      check("done_eq_valid", {31'd0, step_done}, {31'd0, sample_valid});
      check("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sample", {14'd0, sample}, {14'd0, mon_e.smp});
        check("sat_flag", {31'd0, sat_flag}, {31'd0, mon_e.sat});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input int a, input logic [W-1:0] d);
    load_en   = 1'b1;
    load_addr = 5'(a);
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic load_all(input logic [W-1:0] d);
    for (int a = 0; a < N5; a++) load(a, d);
  endtask

  // Issue one step, push its expectation, and check busy and step latency.
  // With poke set, load_en and step_start are pulsed mid-SCAN and tap_addr is changed.
  task automatic run_step(input int tap, input logic [W-1:0] es, input logic esat, input bit poke);
    int t0, lat;
    bit found;
    sb.push_back({es, esat});
    tap_addr   = 5'(tap);
    step_start = 1'b1;
    tick();
    t0         = cyc;
    step_start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    found = 1'b0;
    lat   = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (poke && k == 6) begin
        load_en    = 1'b1;
        step_start = 1'b1;
        load_addr  = 5'd13;
        load_data  = 18'h07000;
        tap_addr   = 5'd0;
      end else if (poke && k == 7) begin
        load_en    = 1'b0;
        step_start = 1'b0;
      end
      if (step_done) begin
        found = 1'b1;
        lat   = cyc + 1 - t0;
      end
    end
    check("step_done_seen", {31'd0, found}, 32'd1);
    check("latency", lat, N5 + 4);
    tick();
  endtask

  initial begin
    int t0, lat;
    bit found;

    // Reset state, then a step on the cleared grid (out-of-range load ignored).
    tick();
    do_reset();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sample", {14'd0, sample}, 32'd0);
    check("rst_sat", {31'd0, sat_flag}, 32'd0);
    check("rst_done", {31'd0, step_done}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_busy_b", {31'd0, busy_b}, 32'd0);
    load(31, 18'h04000);
    load(25, 18'h04000);
    run_step(12, 18'h00000, 1'b0, 1'b0);

    // Full 10x10 step latency and single-cycle pulses.
    tap_addr_b   = 7'd55;
    step_start_b = 1'b1;
    tick();
    t0           = cyc;
    step_start_b = 1'b0;
    check("b_busy_after_start", {31'd0, busy_b}, 32'd1);
    found = 1'b0;
    lat   = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (step_done_b) begin
        found = 1'b1;
        lat   = cyc + 1 - t0;
        check("b_valid", {31'd0, sample_valid_b}, 32'd1);
        check("b_sample", {14'd0, sample_b}, 32'd0);
        check("b_busy_done", {31'd0, busy_b}, 32'd0);
      end
    end
    check("b_done_seen", {31'd0, found}, 32'd1);
    check("b_latency", lat, N10 + 4);
    @(negedge clk);
    check("b_done_pulse", {31'd0, step_done_b}, 32'd0);
    check("b_valid_pulse", {31'd0, sample_valid_b}, 32'd0);
    tick();

    // Single impulse: right neighbour and centre responses.
    do_reset();
    load(12, 18'h04000);
    run_step(13, 18'h00FFC, 1'b0, 1'b0);
    do_reset();
    load(12, 18'h04000);
    run_step(12, 18'h00010, 1'b0, 1'b0);

    // Inputs pulsed mid-SCAN must not disturb the step or start another.
    do_reset();
    load(12, 18'h04000);
    run_step(13, 18'h00FFC, 1'b0, 1'b1);
    repeat (40) tick();

    // Load and start in the same idle cycle: load wins, no step begins.
    do_reset();
    load_en    = 1'b1;
    step_start = 1'b1;
    load_addr  = 5'd12;
    load_data  = 18'h04000;
    tap_addr   = 5'd13;
    tick();
    load_en    = 1'b0;
    step_start = 1'b0;
    check("same_cycle_busy0", {31'd0, busy}, 32'd0);
    tick();
    check("same_cycle_busy1", {31'd0, busy}, 32'd0);
    run_step(12, 18'h00010, 1'b0, 1'b0);

    // Uniform full-scale grid stays just inside range.
    do_reset();
    load_all(18'h1FFFF);
    run_step(12, 18'h1FFFE, 1'b0, 1'b0);

    // Inverted centre node: first step in range, second step clips high.
    do_reset();
    load_all(18'h1FFFF);
    load(12, 18'h20000);
    run_step(12, 18'h1FF00, 1'b0, 1'b0);
    run_step(12, 18'h1FFFF, 1'b1, 1'b0);
    load_all(18'h00000);
    run_step(12, 18'h00000, 1'b1, 1'b0);
    check("sat_sticky", {31'd0, sat_flag}, 32'd1);
    do_reset();
    check("sat_cleared", {31'd0, sat_flag}, 32'd0);

    // Reset mid-SCAN aborts the step and clears the grid.
    load(12, 18'h04000);
    tap_addr   = 5'd12;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    repeat (8) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, step_done}, 32'd0);
    repeat (40) tick();
    run_step(12, 18'h00000, 1'b0, 1'b0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
